// File: rtl/mycpu_pkg.sv
// Shared constants for the CPU IO block.
// Register offsets are decoded from a_in[2:0]. STAT bit positions describe
// the status word returned at IO_STAT.
package mycpu_pkg;

  localparam int unsigned IoDataW = 16;

  // Register offsets within the 8-word IO window
  localparam logic [2:0] IO_GPO  = 3'd0;
  localparam logic [2:0] IO_GPI  = 3'd1;
  localparam logic [2:0] IO_CNT  = 3'd2;
  localparam logic [2:0] IO_PER  = 3'd3;
  localparam logic [2:0] IO_STAT = 3'd4;
  localparam logic [2:0] IO_QDAT = 3'd5;

  // STAT bit positions
  localparam int unsigned STAT_WRAP    = 0;
  localparam int unsigned STAT_EMPTY   = 1;
  localparam int unsigned STAT_FULL    = 2;
  localparam int unsigned STAT_LVL_LSB = 3;
  localparam int unsigned STAT_LVL_W   = 3;
  localparam int unsigned STAT_OVF     = 6;

endpackage

// File: rtl/fifo_4x16.sv
// 4-entry, 16-bit first-in first-out queue.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   push, din    write request and data (ignored when full unless popping)
//   pop          read request (ignored when empty)
//   dout         head entry
//   full, empty  occupancy flags
//   level        number of stored entries, 0..4
module fifo_4x16
  import mycpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic               pop,
  input  logic [IoDataW-1:0] din,
  output logic [IoDataW-1:0] dout,
  output logic               full,
  output logic               empty,
  output logic [2:0]         level
);

  logic [IoDataW-1:0] mem_q [4];
  logic [1:0]         wr_ptr_q, wr_ptr_d;
  logic [1:0]         rd_ptr_q, rd_ptr_d;
  logic [2:0]         level_q, level_d;
  logic               do_push, do_pop;

  assign empty = (level_q == 3'd0);
  assign full  = (level_q == 3'd4);
  assign level = level_q;
  assign dout  = mem_q[rd_ptr_q];

  assign do_pop  = pop && !empty;
  // A full queue can still accept data when the head leaves on the same edge
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 2'd1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 2'd1;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 3'd1;
      2'b01:   level_d = level_q - 3'd1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      level_q  <= 3'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage carries no reset; contents are only observed while level > 0
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/io_unit.sv
// CPU IO block: output port, synchronised input port, interval timer and a
// transmit queue, mapped onto an 8-word register window that aliases across
// the whole IO space.
// Ports:
//   clk, rst_n                 clock and asynchronous active-low reset
//   a_in, d_in, wen_in, iom_in CPU bus (writes need wen_in and iom_in high)
//   io_out                     combinational read data
//   gpi_in                     asynchronous input pins
//   gpo_out                    output port register
//   q_data_out, q_valid_out,
//   q_ready_in                 transmit queue stream
module io_unit
  import mycpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [15:0]        a_in,
  input  logic [IoDataW-1:0] d_in,
  input  logic               wen_in,
  input  logic               iom_in,
  output logic [IoDataW-1:0] io_out,
  input  logic [IoDataW-1:0] gpi_in,
  output logic [IoDataW-1:0] gpo_out,
  output logic [IoDataW-1:0] q_data_out,
  output logic               q_valid_out,
  input  logic               q_ready_in
);

  logic [2:0] addr;
  logic       unused_addr_hi;
  logic       wr;
  logic       wr_gpo, wr_cnt, wr_per, wr_stat, wr_qdat;

  logic [IoDataW-1:0] gpo_q, gpo_d;
  logic [IoDataW-1:0] sync1_q, sync2_q;
  logic [IoDataW-1:0] cnt_q, cnt_d;
  logic [IoDataW-1:0] per_q, per_d;
  logic               wrap_q, wrap_d;
  logic               ovf_q, ovf_d;
  logic               match;

  logic               q_push, q_pop, q_full, q_empty;
  logic [2:0]         q_level;
  logic [IoDataW-1:0] stat;

  // Only the low three address bits decode; the rest alias
  assign addr           = a_in[2:0];
  assign unused_addr_hi = ^a_in[15:3];

  assign wr      = wen_in && iom_in;
  assign wr_gpo  = wr && (addr == IO_GPO);
  assign wr_cnt  = wr && (addr == IO_CNT);
  assign wr_per  = wr && (addr == IO_PER);
  assign wr_stat = wr && (addr == IO_STAT);
  assign wr_qdat = wr && (addr == IO_QDAT);

  // Queue handshake
  assign q_valid_out = !q_empty;
  assign q_pop       = q_valid_out && q_ready_in;
  assign q_push      = wr_qdat && (!q_full || q_pop);

  fifo_4x16 u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (q_push),
    .pop   (q_pop),
    .din   (d_in),
    .dout  (q_data_out),
    .full  (q_full),
    .empty (q_empty),
    .level (q_level)
  );

  // A zero period freezes the timer; a count above the period runs on through
  // 0xFFFF -> 0 until it meets the period.
  assign match = (per_q != '0) && (cnt_q == per_q);

  always_comb begin
    gpo_d = wr_gpo ? d_in : gpo_q;
    per_d = wr_per ? d_in : per_q;

    cnt_d = cnt_q;
    if (per_q != '0) cnt_d = match ? '0 : cnt_q + 16'd1;
    // A CPU load overrides the timer, but a coincident match still flags wrap
    if (wr_cnt) cnt_d = d_in;

    // Set beats W1C when both land on the same edge
    wrap_d = wrap_q;
    if (wr_stat && d_in[STAT_WRAP]) wrap_d = 1'b0;
    if (match) wrap_d = 1'b1;

    ovf_d = ovf_q;
    if (wr_stat && d_in[STAT_OVF]) ovf_d = 1'b0;
    if (wr_qdat && !q_push) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gpo_q   <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      cnt_q   <= '0;
      per_q   <= '0;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      gpo_q   <= gpo_d;
      sync1_q <= gpi_in;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
    end
  end

  assign gpo_out = gpo_q;

  always_comb begin
    stat                                   = '0;
    stat[STAT_WRAP]                        = wrap_q;
    stat[STAT_EMPTY]                       = q_empty;
    stat[STAT_FULL]                        = q_full;
    stat[STAT_LVL_LSB +: STAT_LVL_W]       = q_level;
    stat[STAT_OVF]                         = ovf_q;
  end

  // Read path has no dependence on wen_in/iom_in
  always_comb begin
    io_out = '0;
    case (addr)
      IO_GPO:  io_out = gpo_q;
      IO_GPI:  io_out = sync2_q;
      IO_CNT:  io_out = cnt_q;
      IO_PER:  io_out = per_q;
      IO_STAT: io_out = stat;
      default: io_out = '0;
    endcase
  end

endmodule
